// File: rtl/scan_select_sequencer.sv
// rtl/scan_select_sequencer.sv - channel scan sequencer driving a 4-to-16 one-hot selector
//
// Steps a 4-bit select code through the channels enabled in a latched 16-bit
// mask, holding each for a programmable dwell time, with a forced-off gap
// (dis=1) between channels so the selector never switches while enabled.
//
// Optional feature macro: SCAN_PASS_CNT_EN (completed-pass counter on pass_cnt).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin scan (sampled only in IDLE)
//   loop      in   latched at start; 1 = rescan continuously
//   mask      in   [15:0] channel enable mask, latched at start
//   dwell     in   [DWELL_W-1:0] cycles per channel, latched at start (0 acts as 1)
//   hold      in   freeze dwell countdown, channel stays selected
//   abort     in   terminate scan at next edge, no done pulse
//   sel       out  [3:0] channel code to selector
//   dis       out  selector disable, 1 = all outputs low
//   busy      out  high from accepted start until back in IDLE
//   done      out  one-cycle pulse on completion of a single pass
//   pass_cnt  out  [7:0] completed-pass count (0 when feature disabled)

module scan_select_sequencer #(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               loop,
    input  logic [15:0]        mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    input  logic               abort,
    output logic [3:0]         sel,
    output logic               dis,
    output logic               busy,
    output logic               done,
    output logic [7:0]         pass_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEEK   = 3'd1;
    localparam logic [2:0] ST_DWELL  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [3:0]         GAP_LOAD  = 4'(GAP_CYCLES);

    logic [2:0]         state;
    logic [4:0]         ptr;      // 5 bits so "past channel 15" (16) is representable
    logic [15:0]        mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [3:0]         gap_cnt;

    logic               found;
    logic [3:0]         found_idx;

    // Lowest enabled channel at or above ptr; descending loop so the
    // last assignment wins with the lowest index.
    always_comb begin
        found     = 1'b0;
        found_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i] && (5'(i) >= ptr)) begin
                found     = 1'b1;
                found_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 5'd0;
            mask_q    <= 16'd0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            dwell_cnt <= '0;
            gap_cnt   <= 4'd0;
            sel       <= 4'd0;
            dis       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && abort) begin
                // Abort outranks hold, start and every counter event.
                state <= ST_IDLE;
                dis   <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        dis <= 1'b1;
                        if (start && !abort) begin
                            mask_q  <= mask;
                            dwell_q <= dwell;
                            loop_q  <= loop;
                            ptr     <= 5'd0;
                            busy    <= 1'b1;
                            state   <= ST_SEEK;
                        end
                    end
                    ST_SEEK: begin
                        if (found) begin
                            // dis was high for the whole gap/seek, so changing
                            // sel together with dropping dis cannot glitch.
                            sel       <= found_idx;
                            dis       <= 1'b0;
                            dwell_cnt <= (dwell_q == '0) ? DWELL_ONE : dwell_q;
                            state     <= ST_DWELL;
                        end else if (loop_q && mask_q != 16'd0) begin
                            ptr <= 5'd0;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end
                    end
                    ST_DWELL: begin
                        if (!hold) begin
                            if (dwell_cnt == DWELL_ONE) begin
                                dis     <= 1'b1;
                                ptr     <= {1'b0, sel} + 5'd1;
                                gap_cnt <= GAP_LOAD;
                                state   <= ST_GAP;
                            end else begin
                                dwell_cnt <= dwell_cnt - DWELL_ONE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt <= 4'd1) begin
                            state <= ST_SEEK;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    ST_FINISH: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        dis   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SCAN_PASS_CNT_EN
    // A pass ends whenever SEEK runs out of channels: that is either a loop
    // wrap or entry to FINISH.
    logic pass_evt;
    assign pass_evt = (state == ST_SEEK) && !found && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= 8'd0;
        end else if (state == ST_IDLE && start && !abort) begin
            pass_cnt <= 8'd0;
        end else if (pass_evt) begin
            pass_cnt <= pass_cnt + 8'd1;
        end
    end
`else
    assign pass_cnt = 8'd0;
`endif

endmodule
